// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the Wishbone round-robin arbiter.
// WB_ARB_TIMEOUT_EN adds the watchdog TMO state to the FSM encoding.
package wb_arb_pkg;

`ifdef WB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_OWNED = 2'd1, ST_TMO = 2'd2} arb_state_e;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_OWNED = 2'd1} arb_state_e;
`endif

  localparam int DEF_NUM_MASTERS    = 4;
  localparam int DEF_TIMEOUT_CYCLES = 256;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational round-robin selector: first requester after last_owner,
// wrapping from NUM_MASTERS-1 back to 0.
module wb_rr_picker
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS
) (
  input  logic [NUM_MASTERS-1:0]            req,
  input  logic [idx_width(NUM_MASTERS)-1:0] last_owner,
  output logic [NUM_MASTERS-1:0]            gnt,
  output logic [idx_width(NUM_MASTERS)-1:0] idx,
  output logic                              valid
);

  localparam int IW = idx_width(NUM_MASTERS);

  logic          hi_found, lo_found;
  logic [IW-1:0] hi_idx, lo_idx;

  // Descending scan leaves the lowest index in each half; the half above
  // last_owner outranks the wrapped half.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = NUM_MASTERS - 1; j >= 0; j--) begin
      if (req[j]) begin
        if (j > int'(last_owner)) begin
          hi_found = 1'b1;
          hi_idx   = IW'(j);
        end else begin
          lo_found = 1'b1;
          lo_idx   = IW'(j);
        end
      end
    end
    valid = hi_found | lo_found;
    idx   = hi_found ? hi_idx : lo_idx;
    gnt   = valid ? (NUM_MASTERS'(1) << idx) : '0;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter sharing one slave among NUM_MASTERS masters.
// WB_ARB_TIMEOUT_EN enables the stalled-slave watchdog (TMO state).
//   state | meaning
//   IDLE  | no owner, slave outputs and terminations held at 0
//   OWNED | one master routed to the slave until it drops cyc and lock
//   TMO   | one-cycle watchdog error to the owner, stb suppressed
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = DEF_NUM_MASTERS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      RST_I,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS-1:0]    m_lock_i,
  input  logic [NUM_MASTERS*64-1:0] m_adr_i,
  input  logic [NUM_MASTERS*64-1:0] m_dat_i,
  input  logic [NUM_MASTERS*8-1:0]  m_sel_i,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic [NUM_MASTERS-1:0]    m_rty_o,
  output logic [63:0]               m_dat_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  output logic                      s_lock_o,
  output logic [63:0]               s_adr_o,
  output logic [63:0]               s_dat_o,
  output logic [7:0]                s_sel_o,
  input  logic [63:0]               s_dat_i,
  input  logic                      s_ack_i,
  input  logic                      s_err_i,
  input  logic                      s_rty_i,
  output logic [NUM_MASTERS-1:0]    gnt_o
);

  localparam int IW = idx_width(NUM_MASTERS);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [IW-1:0]          owner_q, owner_d, last_q, last_d;
  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IW-1:0]          pick_idx;
  logic                   pick_valid;
  logic                   own_cyc, own_stb, own_we, own_lock;
  logic [63:0]            own_adr, own_dat;
  logic [7:0]             own_sel;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = idx_width(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stall;
`endif

  wb_rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
    .req        (m_cyc_i),
    .last_owner (last_q),
    .gnt        (pick_gnt),
    .idx        (pick_idx),
    .valid      (pick_valid)
  );

  always_comb begin
    own_cyc  = 1'b0;
    own_stb  = 1'b0;
    own_we   = 1'b0;
    own_lock = 1'b0;
    own_adr  = '0;
    own_dat  = '0;
    own_sel  = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (owner_q == IW'(k)) begin
        own_cyc  = m_cyc_i[k];
        own_stb  = m_stb_i[k];
        own_we   = m_we_i[k];
        own_lock = m_lock_i[k];
        own_adr  = m_adr_i[64*k +: 64];
        own_dat  = m_dat_i[64*k +: 64];
        own_sel  = m_sel_i[8*k +: 8];
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  assign stall = (state_q == ST_OWNED) && own_stb && !(s_ack_i || s_err_i || s_rty_i);
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
`ifdef WB_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_OWNED;
          gnt_d   = pick_gnt;
          owner_d = pick_idx;
        end
      end
      ST_OWNED: begin
        if (!own_cyc && !own_lock) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          last_d  = owner_q;
`ifdef WB_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (stall) begin
          if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            state_d = ST_TMO;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = '0;
        end
`endif
      end
`ifdef WB_ARB_TIMEOUT_EN
      ST_TMO:  state_d = ST_OWNED;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST_I) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_lock_o = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    m_ack_o  = '0;
    m_err_o  = '0;
    m_rty_o  = '0;
    if (state_q != ST_IDLE) begin
      s_cyc_o  = own_cyc;
      s_stb_o  = own_stb;
      s_we_o   = own_we;
      s_lock_o = own_lock;
      s_adr_o  = own_adr;
      s_dat_o  = own_dat;
      s_sel_o  = own_sel;
      m_ack_o  = gnt_q & {NUM_MASTERS{s_ack_i}};
      m_err_o  = gnt_q & {NUM_MASTERS{s_err_i}};
      m_rty_o  = gnt_q & {NUM_MASTERS{s_rty_i}};
`ifdef WB_ARB_TIMEOUT_EN
      if (state_q == ST_TMO) begin
        s_stb_o = 1'b0;
        m_ack_o = '0;
        m_rty_o = '0;
        m_err_o = gnt_q;
      end
`endif
    end
  end

  assign m_dat_o = s_dat_i;
  assign gnt_o   = gnt_q;

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 4, number of requesting Wishbone masters (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 256, watchdog limit in clk cycles (used only with the macro in REQ-024).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 RST_I  input  1  synchronous, active-high reset.
REQ-005 m_cyc_i, m_stb_i, m_we_i, m_lock_i  input  NUM_MASTERS each  per-master cycle, strobe, write enable and lock.
REQ-006 m_adr_i, m_dat_i  input  NUM_MASTERS*64 each  per-master address and write data; master k occupies bits [64k+63:64k].
REQ-007 m_sel_i  input  NUM_MASTERS*8  per-master byte selects.
REQ-008 m_ack_o, m_err_o, m_rty_o  output  NUM_MASTERS each  per-master termination.
REQ-009 m_dat_o  output  64  read data, broadcast to all masters.
REQ-010 s_cyc_o, s_stb_o, s_we_o, s_lock_o  output  1 each  shared-slave control.
REQ-011 s_adr_o, s_dat_o  output  64 each; s_sel_o  output  8  shared-slave address, write data and selects.
REQ-012 s_dat_i  input  64; s_ack_i, s_err_i, s_rty_i  input  1 each  slave read data and terminations.
REQ-013 gnt_o  output  NUM_MASTERS  one-hot registered grant; all zero when idle.

Function
REQ-014 FSM states: IDLE, OWNED, TMO; IDLE after reset.
REQ-015 IDLE: if any m_cyc_i is high, grant the first requester found round-robin starting at last_owner+1 (wrapping at NUM_MASTERS-1 to 0), load gnt_o, go to OWNED; otherwise stay in IDLE.
REQ-016 Latency: s_cyc_o is asserted one cycle after the winning m_cyc_i is sampled high in IDLE.
REQ-017 OWNED: s_cyc_o, s_stb_o, s_we_o, s_lock_o, s_adr_o, s_dat_o, s_sel_o are combinational copies of the owner's inputs; the outputs of non-owners are never routed to the slave.
REQ-018 OWNED: the owner's m_ack_o/m_err_o/m_rty_o equal s_ack_i/s_err_i/s_rty_i combinationally; every other master sees 0 on all three.
REQ-019 m_dat_o equals s_dat_i at all times.
REQ-020 Release: when the owner's m_cyc_i and m_lock_i are both low, clear gnt_o, update last_owner, and enter IDLE on the next edge; requests arriving during OWNED wait, giving one dead cycle between owners.
REQ-021 Lock: while the owner holds m_lock_i high, the grant is kept even if m_cyc_i drops.
REQ-022 Simultaneous requests are resolved by REQ-015 only; a master that has just released has the lowest priority in the next arbitration.
REQ-023 In IDLE, all s_* outputs and all m_ack_o/m_err_o/m_rty_o are 0.

Configuration
REQ-024 Macro WB_ARB_TIMEOUT_EN: when defined, a counter counts OWNED cycles with s_stb_o high and no s_ack_i/s_err_i/s_rty_i. When the count reaches TIMEOUT_CYCLES-1 the FSM enters TMO for one cycle. In TMO, s_stb_o=0 and the owner's m_err_o=1. The FSM then returns to OWNED with the counter cleared.
REQ-025 Without WB_ARB_TIMEOUT_EN: there is no counter and no TMO state, and a stalled slave holds the grant indefinitely.

Reset
REQ-026 With RST_I high at an edge: FSM=IDLE, gnt_o=0, last_owner=NUM_MASTERS-1 (master 0 wins the first arbitration), timeout counter=0.
REQ-027 Reset asserted mid-transfer aborts the transfer; no termination is returned to the former owner.

Structure
REQ-028 Package wb_arb_pkg holds the FSM state enum, the default NUM_MASTERS, and the default TIMEOUT_CYCLES.
REQ-029 Sub-module wb_rr_picker: combinational round-robin selector (request vector, last_owner) -> one-hot grant plus index.

Verification
REQ-030 Masters 0 and 2 raise m_cyc_i in the same cycle after reset -> gnt_o=0001 one cycle later; after master 0 releases, there is one idle cycle and then gnt_o=0100.
REQ-031 Master 1 reads 0x10 and the slave returns ack with s_dat_i=0xDEADBEEF -> m_ack_o=0010 in the same cycle and m_dat_o=0xDEADBEEF.
REQ-032 Master 3 holds m_lock_i high, drops m_cyc_i for 2 cycles, and master 0 requests meanwhile -> gnt_o stays 1000 until m_lock_i falls.
REQ-033 With the macro defined and TIMEOUT_CYCLES=16, the slave never acks -> the owner's m_err_o pulses for exactly 1 cycle, 16 cycles after s_stb_o rose.
REQ-034 RST_I pulsed during an OWNED write -> the next cycle shows all outputs 0 and gnt_o=0, and a later request from master 0 is granted first.
